// File: rtl/mmio_io_bank.sv
// Memory-mapped I/O register bank between the CPU data port and the board I/O.
// Holds synchronised switches, debounced buttons with sticky W1C press events
// and a masked irq, the LED / flag / tube output registers and a cycle counter.
module mmio_io_bank #(
  parameter int unsigned N_SW    = 24,
  parameter int unsigned N_BTN   = 5,
  parameter int unsigned N_FLAG  = 4,
  parameter int unsigned DEB_CYC = 20000
) (
  input  logic              data_clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       write_data,
  input  logic              wea,
  output logic [31:0]       read_data,
  input  logic [N_SW-1:0]   switches,
  input  logic [N_BTN-1:0]  buttons,
  output logic [15:0]       led_word,
  output logic [N_FLAG-1:0] flag_led,
  output logic [31:0]       tube_word,
  output logic              irq
);

  localparam int unsigned CW = $clog2(DEB_CYC);
  localparam logic [CW-1:0] DebMax = CW'(DEB_CYC - 1);

  // Word indices (addr[7:2])
  localparam logic [5:0] AddrSw     = 6'h01;
  localparam logic [5:0] AddrBtnLvl = 6'h02;
  localparam logic [5:0] AddrBtnEvt = 6'h03;
  localparam logic [5:0] AddrBtnMsk = 6'h04;
  localparam logic [5:0] AddrCycles = 6'h05;
  localparam int unsigned AddrFlag0 = 8;
  localparam logic [5:0] AddrTubeHi = 6'h0C;
  localparam logic [5:0] AddrTubeLo = 6'h0D;
  localparam logic [5:0] AddrLed    = 6'h0E;

  logic [5:0] word;
  logic       unused_addr;

  assign word        = addr[7:2];
  assign unused_addr = ^{addr[31:8], addr[1:0]};

  logic [N_SW-1:0]  sw_meta_q, sw_sync_q;
  logic [N_BTN-1:0] btn_meta_q, btn_sync_q;
  logic [N_BTN-1:0] btn_stable_q, btn_stable_d;
  logic [CW-1:0]    deb_cnt_q [N_BTN];
  logic [CW-1:0]    deb_cnt_d [N_BTN];
  logic [N_BTN-1:0] btn_evt_q, btn_evt_d, evt_clr;
  logic [N_BTN-1:0] btn_mask_q;
  logic [31:0]      cycles_q, cycles_d;
  logic [31:0]      flag_q [N_FLAG];
  logic [31:0]      tube_hi_q, tube_lo_q, led_q;
  logic             irq_q;

  logic wr_evt, wr_msk, wr_cyc, wr_thi, wr_tlo, wr_led;

  assign wr_evt = wea && (word == AddrBtnEvt);
  assign wr_msk = wea && (word == AddrBtnMsk);
  assign wr_cyc = wea && (word == AddrCycles);
  assign wr_thi = wea && (word == AddrTubeHi);
  assign wr_tlo = wea && (word == AddrTubeLo);
  assign wr_led = wea && (word == AddrLed);

  // 2-FF synchronisers for switches and buttons
  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      sw_meta_q  <= switches;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= buttons;
      btn_sync_q <= btn_meta_q;
    end
  end

  // Per-button debounce: a differing level must persist DEB_CYC cycles to be accepted
  always_comb begin
    btn_stable_d = btn_stable_q;
    for (int i = 0; i < int'(N_BTN); i++) begin
      deb_cnt_d[i] = '0;
      if (btn_sync_q[i] != btn_stable_q[i]) begin
        if (deb_cnt_q[i] == DebMax) begin
          btn_stable_d[i] = btn_sync_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Sticky press events: a rising stable edge beats a simultaneous W1C
  always_comb begin
    evt_clr   = wr_evt ? write_data[N_BTN-1:0] : '0;
    btn_evt_d = (btn_evt_q & ~evt_clr) | (btn_stable_d & ~btn_stable_q);
  end

  // Free-running counter; a store replaces the count for this cycle
  always_comb begin
    cycles_d = wr_cyc ? write_data : cycles_q + 32'd1;
  end

  // Debounce, event, mask, counter and irq state
  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      btn_stable_q <= '0;
      btn_evt_q    <= '0;
      btn_mask_q   <= '0;
      cycles_q     <= '0;
      irq_q        <= 1'b0;
      for (int i = 0; i < int'(N_BTN); i++) deb_cnt_q[i] <= '0;
    end else begin
      btn_stable_q <= btn_stable_d;
      btn_evt_q    <= btn_evt_d;
      cycles_q     <= cycles_d;
      irq_q        <= |(btn_evt_q & btn_mask_q);
      if (wr_msk) btn_mask_q <= write_data[N_BTN-1:0];
      for (int i = 0; i < int'(N_BTN); i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  // Output-facing RW registers
  always_ff @(posedge data_clk or posedge rst) begin
    if (rst) begin
      tube_hi_q <= '0;
      tube_lo_q <= '0;
      led_q     <= '0;
      for (int i = 0; i < int'(N_FLAG); i++) flag_q[i] <= '0;
    end else begin
      if (wr_thi) tube_hi_q <= write_data;
      if (wr_tlo) tube_lo_q <= write_data;
      if (wr_led) led_q <= write_data;
      for (int i = 0; i < int'(N_FLAG); i++) begin
        if (wea && (word == 6'(AddrFlag0 + i))) flag_q[i] <= write_data;
      end
    end
  end

  // Combinational read mux; unmapped words read 0
  always_comb begin
    read_data = '0;
    case (word)
      AddrSw:     read_data = 32'(sw_sync_q);
      AddrBtnLvl: read_data = 32'(btn_stable_q);
      AddrBtnEvt: read_data = 32'(btn_evt_q);
      AddrBtnMsk: read_data = 32'(btn_mask_q);
      AddrCycles: read_data = cycles_q;
      AddrTubeHi: read_data = tube_hi_q;
      AddrTubeLo: read_data = tube_lo_q;
      AddrLed:    read_data = led_q;
      default:    read_data = '0;
    endcase
    for (int i = 0; i < int'(N_FLAG); i++) begin
      if (word == 6'(AddrFlag0 + i)) read_data = flag_q[i];
    end
  end

  // Flag LEDs light when the corresponding flag register is non-zero
  always_comb begin
    flag_led = '0;
    for (int i = 0; i < int'(N_FLAG); i++) flag_led[i] = |flag_q[i];
  end

  assign led_word  = led_q[15:0];
  assign tube_word = {tube_hi_q[15:0], tube_lo_q[15:0]};
  assign irq       = irq_q;

endmodule

// File: tb/tb_mmio_io_bank.sv
// Directed self-checking bench for mmio_io_bank with a short debounce window.
module tb_mmio_io_bank;

  localparam int unsigned N_SW    = 24;
  localparam int unsigned N_BTN   = 5;
  localparam int unsigned N_FLAG  = 4;
  localparam int unsigned DEB_CYC = 8;

  logic              data_clk = 1'b0;
  logic              rst;
  logic [31:0]       addr;
  logic [31:0]       write_data;
  logic              wea;
  logic [31:0]       read_data;
  logic [N_SW-1:0]   switches;
  logic [N_BTN-1:0]  buttons;
  logic [15:0]       led_word;
  logic [N_FLAG-1:0] flag_led;
  logic [31:0]       tube_word;
  logic              irq;

  int checks = 0;
  int errors = 0;

  mmio_io_bank #(
    .N_SW(N_SW),
    .N_BTN(N_BTN),
    .N_FLAG(N_FLAG),
    .DEB_CYC(DEB_CYC)
  ) dut (
    .data_clk(data_clk),
    .rst(rst),
    .addr(addr),
    .write_data(write_data),
    .wea(wea),
    .read_data(read_data),
    .switches(switches),
    .buttons(buttons),
    .led_word(led_word),
    .flag_led(flag_led),
    .tube_word(tube_word),
    .irq(irq)
  );

  always #5 data_clk = ~data_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge
  task automatic step(input int n);
    repeat (n) @(posedge data_clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, read_data, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr       = a;
    write_data = d;
    wea        = 1'b1;
    step(1);
    wea        = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    wea        = 1'b0;
    addr       = 32'h0;
    write_data = 32'h0;
    switches   = '0;
    buttons    = '0;

    // T1: reset holds every output at 0 regardless of inputs
    for (int i = 0; i < 3; i++) begin
      switches   = N_SW'($urandom);
      buttons    = N_BTN'($urandom);
      write_data = $urandom;
      step(1);
      check("rst_led", 32'(led_word), 32'h0);
      check("rst_tube", tube_word, 32'h0);
      check("rst_flag", 32'(flag_led), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      rd_check("rst_sw", 32'h04, 32'h0);
    end
    switches = 24'hA5A5A5;
    buttons  = '0;
    rst      = 1'b0;
    addr     = 32'h14;
    step(1);
    rd_check("cycles_1", 32'h14, 32'd1);
    rd_check("sw_one_ff", 32'h04, 32'h0);
    step(1);
    rd_check("cycles_2", 32'h14, 32'd2);
    rd_check("sw_synced", 32'h04, 32'h00A5A5A5);
    step(1);
    rd_check("cycles_3", 32'h14, 32'd3);

    // T2: bouncing button 2 is only accepted 2+8 edges after its final edge
    for (int i = 0; i < 3; i++) begin
      buttons = 5'b00100;
      step(3);
      buttons = 5'b00000;
      step(3);
    end
    rd_check("bounce_lvl", 32'h08, 32'h0);
    buttons = 5'b00100;
    step(9);
    rd_check("deb_lvl_9", 32'h08, 32'h0);
    rd_check("deb_evt_9", 32'h0C, 32'h0);
    step(1);
    rd_check("deb_lvl_10", 32'h08, 32'h4);
    rd_check("deb_evt_10", 32'h0C, 32'h4);

    // T3: W1C and set-wins collision
    buttons = 5'b00101;
    step(10);
    rd_check("evt_5", 32'h0C, 32'h5);
    wr(32'h0C, 32'h1);
    rd_check("w1c_bit0", 32'h0C, 32'h4);
    buttons = 5'b00001;
    step(10);
    rd_check("fall_lvl", 32'h08, 32'h1);
    rd_check("fall_no_evt", 32'h0C, 32'h4);
    wr(32'h0C, 32'h4);
    rd_check("w1c_bit2", 32'h0C, 32'h0);
    buttons = 5'b00101;
    step(9);
    wr(32'h0C, 32'h4);
    rd_check("collision_lvl", 32'h08, 32'h5);
    rd_check("collision_set", 32'h0C, 32'h4);
    wr(32'h0C, 32'h0);
    rd_check("w1c_zero", 32'h0C, 32'h4);
    wr(32'h0C, 32'h4);
    rd_check("w1c_clear", 32'h0C, 32'h0);

    // T4: masked irq
    wr(32'h10, 32'h2);
    rd_check("mask_rd", 32'h10, 32'h2);
    buttons = 5'b00000;
    step(10);
    rd_check("release_evt", 32'h0C, 32'h0);
    buttons = 5'b00001;
    step(11);
    rd_check("btn0_evt", 32'h0C, 32'h1);
    check("irq_masked", 32'(irq), 32'h0);
    buttons = 5'b00011;
    step(10);
    rd_check("btn1_evt", 32'h0C, 32'h3);
    check("irq_lag", 32'(irq), 32'h0);
    step(1);
    check("irq_set", 32'(irq), 32'h1);
    wr(32'h0C, 32'h2);
    rd_check("w1c_btn1", 32'h0C, 32'h1);
    check("irq_hold", 32'(irq), 32'h1);
    step(1);
    check("irq_clr", 32'(irq), 32'h0);

    // T5: output registers
    wr(32'h30, 32'h1234ABCD);
    wr(32'h34, 32'h00005678);
    check("tube_word", tube_word, 32'hABCD5678);
    rd_check("tube_hi_rd", 32'h30, 32'h1234ABCD);
    wr(32'h2C, 32'h100);
    check("flag_led", 32'(flag_led), 32'h8);
    rd_check("flag3_rd", 32'h2C, 32'h100);
    wr(32'h20, 32'h1);
    check("flag_led_2", 32'(flag_led), 32'h9);
    wr(32'h38, 32'hFFFF0F0F);
    check("led_word", 32'(led_word), 32'h0F0F);
    rd_check("led_rd", 32'h38, 32'hFFFF0F0F);

    // T6: decode and counter wrap
    wr(32'h04, 32'hFFFFFFFF);
    wr(32'h3C, 32'hFFFFFFFF);
    rd_check("sw_ro", 32'h04, 32'h00A5A5A5);
    rd_check("unmapped_3c", 32'h3C, 32'h0);
    rd_check("unmapped_00", 32'h00, 32'h0);
    check("led_keep", 32'(led_word), 32'h0F0F);
    check("tube_keep", tube_word, 32'hABCD5678);
    check("flag_keep", 32'(flag_led), 32'h9);
    wr(32'h14, 32'hFFFFFFFE);
    rd_check("cyc_load", 32'h14, 32'hFFFFFFFE);
    step(1);
    rd_check("cyc_max", 32'h14, 32'hFFFFFFFF);
    step(1);
    rd_check("cyc_wrap", 32'h14, 32'h0);
    wr(32'h10, 32'hFFFFFFFF);
    rd_check("mask_width", 32'h10, 32'h1F);
    step(1);
    check("irq_all_mask", 32'(irq), 32'h1);

    // Reset mid-operation clears outputs asynchronously
    buttons = 5'b00010;
    step(3);
    #2;
    rst = 1'b1;
    #1;
    check("rst2_irq", 32'(irq), 32'h0);
    check("rst2_led", 32'(led_word), 32'h0);
    check("rst2_tube", tube_word, 32'h0);
    check("rst2_flag", 32'(flag_led), 32'h0);
    rd_check("rst2_cyc", 32'h14, 32'h0);
    rd_check("rst2_lvl", 32'h08, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
